// File: rtl/store_merge_if.sv
// Store-merge bus bundle: CPU store request/status plus the word-wide memory port.
interface store_merge_if;
  logic        req;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  modport slave (
    input  req, func3, addr, wdata, mem_rdata,
    output busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req, func3, addr, wdata, mem_rdata,
    input  busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/store_merge.sv
// Store merge unit: turns sb/sh/sw stores into word-wide memory writes.
// Sub-word stores do a read-modify-write; aligned sw writes directly.
module store_merge #(
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  store_merge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        is_sb, is_sh, is_sw, legal;
  logic [31:0] merged;

  // Classify the incoming store straight from the request inputs.
  always_comb begin
    is_sb = (bus.func3 == 3'b000);
    is_sh = (bus.func3 == 3'b001);
    is_sw = (bus.func3 == 3'b010);
    legal = is_sb
          | (is_sh & ~bus.addr[0])
          | (is_sw & (bus.addr[1:0] == 2'b00));
  end

  // Next-state logic: accept in IDLE, read, wait out the memory latency, write.
  always_comb begin
    state_d = state_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (bus.req) begin
          if (legal) begin
            func3_d = bus.func3;
            addr_d  = bus.addr;
            wdata_d = bus.wdata;
            state_d = is_sw ? WRITE : READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      READ: begin
        cnt_d   = 2'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          rdata_d = bus.mem_rdata;
          cnt_d   = 2'd0;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      func3_q <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Merge the latched store data into the captured memory word.
  always_comb begin
    merged = rdata_q;
    case (func3_q)
      3'b000: begin
        case (addr_q[1:0])
          2'd0: merged[7:0]   = wdata_q[7:0];
          2'd1: merged[15:8]  = wdata_q[7:0];
          2'd2: merged[23:16] = wdata_q[7:0];
          2'd3: merged[31:24] = wdata_q[7:0];
          default: merged = rdata_q;
        endcase
      end
      3'b001: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      3'b010: merged = wdata_q;
      default: merged = rdata_q;
    endcase
  end

  // Outputs decode registered state only, so reset clears them immediately.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == WRITE);
    bus.err       = err_q;
    bus.mem_re    = (state_q == READ);
    bus.mem_we    = (state_q == WRITE);
    bus.mem_wdata = (state_q == WRITE) ? merged : 32'h0;
    bus.mem_addr  = {addr_q[31:2], 2'b00};
  end

endmodule
